// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: control strobes from the sequencer, PC and instruction back to it.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              PC_Clr;
  logic              PC_Up;
  logic              IR_ld;
  logic [ADDR_W-1:0] pc_out;
  logic [DATA_W-1:0] inst_out;

  modport master (output PC_Clr, PC_Up, IR_ld, input pc_out, inst_out);
  modport slave  (input PC_Clr, PC_Up, IR_ld, output pc_out, inst_out);
endinterface

// File: rtl/instr_fetch_unit.sv
// PC -> registered-address ROM -> IR fetch path; inst_out lags the PC by two edges.
// No backpressure: PC_Clr/PC_Up/IR_ld are applied on every rising edge.
module instr_fetch_unit #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter     INIT_FILE = ""
) (
    input  logic                Clk,
    input  logic                Rst_n,
    instr_fetch_unit_if.slave   bus
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_rom_dat;

    function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
        logic [15:0] w;
        case (int'(a))
            0:       w = 16'h2000;
            1:       w = 16'h2101;
            2:       w = 16'h3201;
            4:       w = 16'h4302;
            5:       w = 16'h1403;
            6:       w = 16'h5000;
            7:       w = 16'h000A;
            8:       w = 16'h2504;
            9:       w = 16'h3605;
            10:      w = 16'h1706;
            11:      w = 16'h5000;
            13:      w = 16'h0001;
            14:      w = 16'h00FF;
            15:      w = 16'hFFFF;
            127:     w = 16'hABCD;
            default: w = 16'h0000;
        endcase
        return DATA_W'(w);
    endfunction

    // ROM data is a combinational look-up of the registered address.
    assign w_rom_dat = default_word(r_addr);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pc   <= '0;
            r_addr <= '0;
            r_ir   <= '0;
        end else begin
            if (bus.PC_Clr)
                r_pc <= '0;
            else if (bus.PC_Up)
                r_pc <= r_pc + 1'b1;
            r_addr <= r_pc;
            if (bus.IR_ld)
                r_ir <= w_rom_dat;
        end
    end

    assign bus.pc_out   = r_pc;
    assign bus.inst_out = r_ir;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed test-plan steps followed by random strobes, checked against a PC-history ROM model.
module tb_instr_fetch_unit;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  instr_fetch_unit_if #(.ADDR_W(7), .DATA_W(16)) bus ();

  instr_fetch_unit #(.ADDR_W(7), .DATA_W(16), .INIT_FILE("")) u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference: PC as an integer, plus the list of PC values seen before each edge.
  int rom_m [128];
  int pc_m;
  int ir_m;
  int hist [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc_m = 0;
    ir_m = 0;
    hist.delete();
    hist.push_back(0);
  endtask

  // One clock edge with the given strobes; the word read is for the PC seen before the previous edge.
  task automatic step(input logic clr, input logic up, input logic ld);
    int rom_word;
    bus.PC_Clr = clr;
    bus.PC_Up  = up;
    bus.IR_ld  = ld;
    rom_word = rom_m[hist[$]];
    if (ld) ir_m = rom_word;
    hist.push_back(pc_m);
    if (hist.size() > 4) void'(hist.pop_front());
    if (clr)     pc_m = 0;
    else if (up) pc_m = (pc_m + 1) % 128;
    @(posedge Clk);
    #1;
    chk("pc_model", 32'(bus.pc_out), 32'(pc_m));
    chk("ir_model", 32'(bus.inst_out), 32'(ir_m));
  endtask

  task automatic async_reset_check();
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", 32'(bus.pc_out), 32'd0);
    chk("rst_ir", 32'(bus.inst_out), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_m[i] = 0;
    rom_m[0] = 'h2000;  rom_m[1] = 'h2101;  rom_m[2] = 'h3201;  rom_m[3] = 'h0000;
    rom_m[4] = 'h4302;  rom_m[5] = 'h1403;  rom_m[6] = 'h5000;  rom_m[7] = 'h000A;
    rom_m[8] = 'h2504;  rom_m[9] = 'h3605;  rom_m[10] = 'h1706; rom_m[11] = 'h5000;
    rom_m[12] = 'h0000; rom_m[13] = 'h0001; rom_m[14] = 'h00FF; rom_m[15] = 'hFFFF;
    rom_m[127] = 'hABCD;

    bus.PC_Clr = 1'b0;
    bus.PC_Up  = 1'b0;
    bus.IR_ld  = 1'b0;
    model_reset();

    // Reset state while held low, spanning a clock edge.
    #12;
    chk("reset_pc", 32'(bus.pc_out), 32'd0);
    chk("reset_ir", 32'(bus.inst_out), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    step(1'b1, 1'b0, 1'b0);
    chk("clr_pc", 32'(bus.pc_out), 32'd0);
    chk("clr_ir", 32'(bus.inst_out), 32'd0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    chk("run5_pc", 32'(bus.pc_out), 32'd5);
    chk("run5_ir", 32'(bus.inst_out), 32'h0000);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("run7_pc", 32'(bus.pc_out), 32'd7);

    // Stall at 7: the IR catches up to ROM[7] after two loads.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("stall_pc", 32'(bus.pc_out), 32'd7);
    chk("stall_ir", 32'(bus.inst_out), 32'h000A);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("hold_ir", 32'(bus.inst_out), 32'h000A);
    chk("hold_pc", 32'(bus.pc_out), 32'd10);

    // Full sweep and wrap.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 127; i++) step(1'b0, 1'b1, 1'b1);
    chk("top_pc", 32'(bus.pc_out), 32'd127);
    step(1'b0, 1'b1, 1'b1);
    chk("wrap_pc", 32'(bus.pc_out), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("wrap_ir", 32'(bus.inst_out), 32'hABCD);

    // Clear and increment together at PC 9.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);
    chk("pre_clr_pc", 32'(bus.pc_out), 32'd9);
    step(1'b1, 1'b1, 1'b1);
    chk("clrup_pc", 32'(bus.pc_out), 32'd0);
    chk("clrup_ir", 32'(bus.inst_out), 32'h2504);

    // Asynchronous reset between edges mid-count.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    async_reset_check();
    step(1'b0, 1'b1, 1'b1);
    chk("post_rst_ir", 32'(bus.inst_out), 32'h2000);
    chk("post_rst_pc", 32'(bus.pc_out), 32'd1);

    // Random strobes with occasional clears and asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset_check();
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
